// File: rtl/simd_controller.sv
// Sequencing FSM for one SIMD unit: steps a resident wave through fetch/decode/memory/execute/writeback,
// replaying each instruction once per wave cycle and producing the per-lane active mask.
module simd_controller #(
   parameter int LANE_WIDTH = 16,
   parameter int WAVE_SIZE = 32,
   localparam int TOTAL_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
   localparam int CW = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    simd_start,
   input  logic [31:0]             wave_id,
   input  logic [31:0]             block_dim,
   input  logic [2:0]              fetcher_state,
   input  logic                    MEM_READ,
   input  logic                    MEM_WRITE,
   input  logic                    RET,
   input  logic [2*LANE_WIDTH-1:0] lsu_state,
   output logic [2:0]              simd_state,
   output logic [CW-1:0]           curr_wave_cycle,
   output logic [LANE_WIDTH-1:0]   lane_mask,
   output logic                    pc_advance,
   output logic                    simd_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      REQUEST = 3'd3,
      WAIT    = 3'd4,
      EXECUTE = 3'd5,
      UPDATE  = 3'd6,
      DONE    = 3'd7
   } state_t;

   localparam logic [CW-1:0] LAST_CYCLE = CW'(TOTAL_WAVE_CYCLES - 1);

   state_t                  state;
   state_t                  next_state;
   logic [CW-1:0]           next_cycle;
   logic                    capture;
   logic                    advance_next;
   logic                    done_next;
   logic                    last_cycle;
   logic                    lanes_ready;
   logic [LANE_WIDTH-1:0]   lane_done;
   logic [31:0]             wave_id_q;
   logic [31:0]             block_dim_q;
   logic [31:0]             cycle_base;
   logic [31:0]             wave_base;
   logic [31:0]             thread;

   assign simd_state = state;
   assign last_cycle = (curr_wave_cycle == LAST_CYCLE);
   assign cycle_base = 32'(curr_wave_cycle) * 32'(LANE_WIDTH);
   assign wave_base  = wave_id_q * 32'(WAVE_SIZE);

   // A lane is active if its thread exists in the wave and falls inside the block.
   always_comb begin
      lane_mask = '0;
      thread    = '0;
      for (int i = 0; i < LANE_WIDTH; i++) begin
         thread       = cycle_base + 32'(i);
         lane_mask[i] = (thread < 32'(WAVE_SIZE)) && ((wave_base + thread) < block_dim_q);
      end
   end

   always_comb begin
      lane_done = '0;
      for (int i = 0; i < LANE_WIDTH; i++) begin
         lane_done[i] = (lsu_state[2*i +: 2] == 2'd3);
      end
   end

   // Inactive lanes never block progress, so an empty mask passes at once.
   assign lanes_ready = &(lane_done | ~lane_mask);

   always_comb begin
      next_state = state;
      next_cycle = curr_wave_cycle;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (simd_start) begin
               next_state = FETCH;
               next_cycle = '0;
               capture    = 1'b1;
            end
         end
         FETCH:   if (fetcher_state == 3'd2) next_state = DECODE;
         DECODE:  next_state = REQUEST;
         REQUEST: next_state = WAIT;
         WAIT:    if (!(MEM_READ | MEM_WRITE) || lanes_ready) next_state = EXECUTE;
         EXECUTE: next_state = UPDATE;
         UPDATE: begin
            if (!last_cycle) begin
               next_cycle = curr_wave_cycle + CW'(1);
               next_state = REQUEST;
            end else begin
               next_cycle = '0;
               next_state = RET ? DONE : FETCH;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Pulses are registered so they line up with the UPDATE and DONE states they belong to.
   assign advance_next = (next_state == UPDATE) && last_cycle && !RET;
   assign done_next    = (next_state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         curr_wave_cycle <= '0;
         wave_id_q       <= '0;
         block_dim_q     <= '0;
         pc_advance      <= 1'b0;
         simd_done       <= 1'b0;
      end else if (enable) begin
         state           <= next_state;
         curr_wave_cycle <= next_cycle;
         if (capture) begin
            wave_id_q   <= wave_id;
            block_dim_q <= block_dim;
         end
         pc_advance      <= advance_next;
         simd_done       <= done_next;
      end else begin
         pc_advance      <= 1'b0;
         simd_done       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_simd_controller.sv
// Directed bench for simd_controller: linear sequence of stimulus steps with hand-computed
// expected state, wave cycle, lane mask and pulse values.
module tb_simd_controller;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        simd_start;
   logic [31:0] wave_id;
   logic [31:0] block_dim;
   logic [2:0]  fetcher_state;
   logic        mem_read;
   logic        mem_write;
   logic        ret;
   logic [31:0] lsu_state;
   logic [2:0]  simd_state;
   logic [0:0]  curr_wave_cycle;
   logic [15:0] lane_mask;
   logic        pc_advance;
   logic        simd_done;

   int vectors;
   int miscompares;

   int exp_state [10] = '{2, 3, 4, 5, 6, 3, 4, 5, 6, 1};
   int exp_cycle [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   int exp_pc    [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

   simd_controller dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .simd_start      (simd_start),
      .wave_id         (wave_id),
      .block_dim       (block_dim),
      .fetcher_state   (fetcher_state),
      .MEM_READ        (mem_read),
      .MEM_WRITE       (mem_write),
      .RET             (ret),
      .lsu_state       (lsu_state),
      .simd_state      (simd_state),
      .curr_wave_cycle (curr_wave_cycle),
      .lane_mask       (lane_mask),
      .pc_advance      (pc_advance),
      .simd_done       (simd_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs, then move to just after the next rising edge.
   task automatic applyStimulus(input logic start, input logic [2:0] fetch, input logic mread,
                                input logic r, input logic [31:0] lsu);
      simd_start    = start;
      fetcher_state = fetch;
      mem_read      = mread;
      ret           = r;
      lsu_state     = lsu;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input int st, input int cyc, input int mask,
                           input int pc, input int done);
      checkOutput($sformatf("%s.state", tag), 32'(simd_state), 32'(st));
      checkOutput($sformatf("%s.cycle", tag), 32'(curr_wave_cycle), 32'(cyc));
      checkOutput($sformatf("%s.mask", tag), 32'(lane_mask), 32'(mask));
      checkOutput($sformatf("%s.pc_advance", tag), 32'(pc_advance), 32'(pc));
      checkOutput($sformatf("%s.simd_done", tag), 32'(simd_done), 32'(done));
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      enable        = 1'b1;
      simd_start    = 1'b0;
      wave_id       = 32'd0;
      block_dim     = 32'd0;
      fetcher_state = 3'd0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ret           = 1'b0;
      lsu_state     = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkAll("reset", 0, 0, 16'h0000, 0, 0);

      // Start a load wave and abort it with reset while it waits on the LSUs.
      rst       = 1'b1;
      wave_id   = 32'd0;
      block_dim = 32'd64;
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 32'd0);
      checkAll("start", 1, 0, 16'hFFFF, 0, 0);
      applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkOutput("wait_stall", 32'(simd_state), 32'd4);
      #2;
      rst = 1'b0;
      #1;
      checkAll("rst_wait", 0, 0, 16'h0000, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkAll("rst_hold", 0, 0, 16'h0000, 0, 0);
      rst = 1'b1;

      // Load with lane 15 late; simd_start held high the whole wave, RET on the last cycle.
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h3FFF_FFFF);
      checkOutput("restart", 32'(simd_state), 32'd1);
      applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 32'h3FFF_FFFF);
      checkOutput("restart_decode", 32'(simd_state), 32'd2);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h3FFF_FFFF);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h3FFF_FFFF);
      checkOutput("load_wait0", 32'(simd_state), 32'd4);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h3FFF_FFFF);
         checkOutput($sformatf("load_wait%0d", k), 32'(simd_state), 32'd4);
      end
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkOutput("load_exec", 32'(simd_state), 32'd5);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkAll("load_upd0", 6, 0, 16'hFFFF, 0, 0);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkAll("load_req1", 3, 1, 16'hFFFF, 0, 0);
      wave_id   = 32'd1;
      block_dim = 32'd40;
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkAll("load_exec1", 5, 1, 16'hFFFF, 0, 0);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkAll("ret_upd1", 6, 1, 16'hFFFF, 0, 0);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checkAll("ret_done", 7, 0, 16'hFFFF, 0, 1);
      wave_id   = 32'd0;
      block_dim = 32'd32;
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("ret_idle", 0, 0, 16'hFFFF, 0, 0);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("alu_start", 1, 0, 16'hFFFF, 0, 0);

      // ALU instruction over both wave cycles, FETCHED presented in cycle f.
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkOutput("fetch_hold", 32'(simd_state), 32'd1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, (k == 0) ? 3'd2 : 3'd0, 1'b0, 1'b0, 32'd0);
         checkOutput($sformatf("alu_f+%0d.state", k + 1), 32'(simd_state), 32'(exp_state[k]));
         checkOutput($sformatf("alu_f+%0d.cycle", k + 1), 32'(curr_wave_cycle), 32'(exp_cycle[k]));
         checkOutput($sformatf("alu_f+%0d.pc", k + 1), 32'(pc_advance), 32'(exp_pc[k]));
      end

      // Freeze for 3 cycles in EXECUTE, and once in the final UPDATE.
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkOutput("en_exec", 32'(simd_state), 32'd5);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
         checkAll($sformatf("en_frozen%0d", k), 5, 0, 16'hFFFF, 0, 0);
      end
      enable = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("en_upd0", 6, 0, 16'hFFFF, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("en_req1", 3, 1, 16'hFFFF, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("en_upd1", 6, 1, 16'hFFFF, 1, 0);
      enable = 1'b0;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("en_upd_frozen", 6, 1, 16'hFFFF, 0, 0);
      enable = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("en_fetch", 1, 0, 16'hFFFF, 0, 0);

      // RET instruction ends the ALU wave; next wave is the partial block.
      wave_id   = 32'd1;
      block_dim = 32'd40;
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 32'd0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
      end
      checkAll("ret2_upd1", 6, 1, 16'hFFFF, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'd0);
      checkAll("ret2_done", 7, 0, 16'hFFFF, 0, 1);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("ret2_idle", 0, 0, 16'hFFFF, 0, 0);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 32'd0);
      checkAll("part_start", 1, 0, 16'h00FF, 0, 0);

      // Partial block: only lanes 0-7 report DONE in cycle 0; no lane is active in cycle 1.
      applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 32'h0000_FFFF);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_FFFF);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_FFFF);
      checkAll("part_wait0", 4, 0, 16'h00FF, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'h0000_FFFF);
      checkOutput("part_exec0", 32'(simd_state), 32'd5);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkAll("part_req1", 3, 1, 16'h0000, 0, 0);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkOutput("part_wait1", 32'(simd_state), 32'd4);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkOutput("part_exec1", 32'(simd_state), 32'd5);
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 32'd0);
      checkAll("part_upd1", 6, 1, 16'h0000, 1, 0);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkAll("part_fetch", 1, 0, 16'h00FF, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
